// File: rtl/mem_bus_arb.sv
// mem_bus_arb: arbitrates a debug port, a CPU data bus and a CPU instruction bus
// onto a single-ported synchronous memory.
//
// Ports
//   clk, reset                   single clock, synchronous active-high reset
//   cpu_run                      gates CPU (iBus/dBus) grants
//   dbg_mem_op/rw/adr/do         debug request level, held until dbg_mem_rdy
//   dbg_mem_rdy, dbg_di          one-cycle debug completion pulse + read data
//   ibus_cmd_*, ibus_rsp_*       instruction fetch command / response
//   dbus_cmd_*, dbus_rsp_*       data command / response (size ignored, mask used)
//   mem_op/adr/di/wren, mem_do   memory port; mem_do valid the cycle after mem_op
//
// state  | meaning
// IDLE   | arbitrate; combinational cmd_ready for the winning CPU master
// ACCESS | mem_op asserted for one cycle with the latched command
// WAIT   | read data on mem_do, captured into the response at the end
// RESP   | one-cycle response pulse (unmapped requests come here from IDLE)

module mem_bus_arb #(
  parameter int         ADR_BITS    = 18,
  parameter logic [1:0] HOLE_REGION = 2'b11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_run,

  input  logic        dbg_mem_op,
  input  logic        dbg_rw,
  input  logic [31:0] dbg_adr,
  input  logic [31:0] dbg_do,
  output logic        dbg_mem_rdy,
  output logic [31:0] dbg_di,

  input  logic        ibus_cmd_valid,
  output logic        ibus_cmd_ready,
  input  logic [31:0] ibus_cmd_pc,
  output logic        ibus_rsp_valid,
  output logic [31:0] ibus_rsp_inst,
  output logic        ibus_rsp_error,

  input  logic        dbus_cmd_valid,
  output logic        dbus_cmd_ready,
  input  logic        dbus_cmd_wr,
  input  logic [3:0]  dbus_cmd_mask,
  input  logic [31:0] dbus_cmd_address,
  input  logic [31:0] dbus_cmd_data,
  input  logic [1:0]  dbus_cmd_size,
  output logic        dbus_rsp_ready,
  output logic [31:0] dbus_rsp_data,
  output logic        dbus_rsp_error,

  output logic        mem_op,
  output logic [31:0] mem_adr,
  output logic [31:0] mem_di,
  output logic [3:0]  mem_wren,
  input  logic [31:0] mem_do
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP} state_t;
  typedef enum logic [1:0] {M_NONE, M_DBG, M_DBUS, M_IBUS} master_t;

  state_t  state;
  master_t lat_master;
  logic    lat_rd;
  logic    rearm;

  logic        idle;
  logic        dbg_win, dbus_win, ibus_win, go;
  master_t     sel_master;
  logic [31:0] sel_adr, sel_data;
  logic [3:0]  sel_wren;
  logic        sel_rd, sel_unmapped;

  // Transfer size is implied by the byte mask; the size field is not needed.
  logic unused_size;
  assign unused_size = ^dbus_cmd_size;

  function automatic logic is_unmapped(input logic [31:0] adr);
    return ((adr >> ADR_BITS) != 32'd0) || (adr[ADR_BITS-1 -: 2] == HOLE_REGION);
  endfunction

  // Reset is folded into idle so no handshake completes while reset is held.
  assign idle     = (state == S_IDLE) && !reset;
  assign dbg_win  = idle && dbg_mem_op && rearm;
  assign dbus_cmd_ready = idle && cpu_run && !dbg_win;
  assign ibus_cmd_ready = idle && cpu_run && !dbg_win && !dbus_cmd_valid;
  assign dbus_win = dbus_cmd_valid && dbus_cmd_ready;
  assign ibus_win = ibus_cmd_valid && ibus_cmd_ready;
  assign go       = dbg_win || dbus_win || ibus_win;

  always_comb begin
    sel_master = M_NONE;
    sel_adr    = 32'd0;
    sel_data   = 32'd0;
    sel_wren   = 4'h0;
    sel_rd     = 1'b0;
    if (dbg_win) begin
      sel_master = M_DBG;
      sel_adr    = dbg_adr;
      sel_rd     = dbg_rw;
      sel_data   = dbg_rw ? 32'd0 : dbg_do;
      sel_wren   = dbg_rw ? 4'h0 : 4'hF;
    end else if (dbus_win) begin
      sel_master = M_DBUS;
      sel_adr    = dbus_cmd_address;
      sel_rd     = !dbus_cmd_wr;
      sel_data   = dbus_cmd_wr ? dbus_cmd_data : 32'd0;
      sel_wren   = dbus_cmd_wr ? dbus_cmd_mask : 4'h0;
    end else if (ibus_win) begin
      sel_master = M_IBUS;
      sel_adr    = ibus_cmd_pc;
      sel_rd     = 1'b1;
    end
  end

  assign sel_unmapped = is_unmapped(sel_adr);

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      lat_master     <= M_NONE;
      lat_rd         <= 1'b0;
      rearm          <= 1'b1;
      mem_op         <= 1'b0;
      mem_adr        <= 32'd0;
      mem_di         <= 32'd0;
      mem_wren       <= 4'h0;
      dbg_mem_rdy    <= 1'b0;
      dbg_di         <= 32'd0;
      ibus_rsp_valid <= 1'b0;
      ibus_rsp_inst  <= 32'd0;
      ibus_rsp_error <= 1'b0;
      dbus_rsp_ready <= 1'b0;
      dbus_rsp_data  <= 32'd0;
      dbus_rsp_error <= 1'b0;
    end else begin
      // Memory strobes and response pulses last exactly one cycle.
      mem_op         <= 1'b0;
      mem_adr        <= 32'd0;
      mem_di         <= 32'd0;
      mem_wren       <= 4'h0;
      dbg_mem_rdy    <= 1'b0;
      dbg_di         <= 32'd0;
      ibus_rsp_valid <= 1'b0;
      ibus_rsp_inst  <= 32'd0;
      ibus_rsp_error <= 1'b0;
      dbus_rsp_ready <= 1'b0;
      dbus_rsp_data  <= 32'd0;
      dbus_rsp_error <= 1'b0;

      // A debug level still high after its completion must drop for a cycle
      // before it can be granted again.
      if (dbg_mem_rdy)
        rearm <= 1'b0;
      else if (!dbg_mem_op)
        rearm <= 1'b1;

      case (state)
        S_IDLE: begin
          if (go) begin
            lat_master <= sel_master;
            lat_rd     <= sel_rd;
            if (sel_unmapped) begin
              state <= S_RESP;
              case (sel_master)
                M_DBG:  dbg_mem_rdy <= 1'b1;
                M_DBUS: begin
                  dbus_rsp_ready <= sel_rd;
                  dbus_rsp_error <= sel_rd;
                end
                M_IBUS: begin
                  ibus_rsp_valid <= 1'b1;
                  ibus_rsp_error <= 1'b1;
                end
                default: ;
              endcase
            end else begin
              state    <= S_ACCESS;
              mem_op   <= 1'b1;
              mem_adr  <= {sel_adr[31:2], 2'b00};
              mem_di   <= sel_data;
              mem_wren <= sel_wren;
            end
          end
        end
        S_ACCESS: begin
          if (lat_rd)
            state <= S_WAIT;
          else if (lat_master == M_DBG) begin
            state       <= S_RESP;
            dbg_mem_rdy <= 1'b1;
          end else
            state <= S_IDLE;
        end
        S_WAIT: begin
          state <= S_RESP;
          case (lat_master)
            M_DBG: begin
              dbg_mem_rdy <= 1'b1;
              dbg_di      <= mem_do;
            end
            M_DBUS: begin
              dbus_rsp_ready <= 1'b1;
              dbus_rsp_data  <= mem_do;
            end
            M_IBUS: begin
              ibus_rsp_valid <= 1'b1;
              ibus_rsp_inst  <= mem_do;
            end
            default: ;
          endcase
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arb.sv
// Scoreboard bench for mem_bus_arb: request tasks push expected memory cycles and
// responses (with the cycle they must appear in); a negedge monitor pops and compares.

module tb_mem_bus_arb;

  logic        clk = 1'b0;
  logic        reset, cpu_run;
  logic        dbg_mem_op, dbg_rw, dbg_mem_rdy;
  logic [31:0] dbg_adr, dbg_do, dbg_di;
  logic        ibus_cmd_valid, ibus_cmd_ready, ibus_rsp_valid, ibus_rsp_error;
  logic [31:0] ibus_cmd_pc, ibus_rsp_inst;
  logic        dbus_cmd_valid, dbus_cmd_ready, dbus_cmd_wr, dbus_rsp_ready, dbus_rsp_error;
  logic [3:0]  dbus_cmd_mask;
  logic [31:0] dbus_cmd_address, dbus_cmd_data, dbus_rsp_data;
  logic [1:0]  dbus_cmd_size;
  logic        mem_op;
  logic [31:0] mem_adr, mem_di, mem_do;
  logic [3:0]  mem_wren;

  mem_bus_arb dut (
    .clk(clk), .reset(reset), .cpu_run(cpu_run),
    .dbg_mem_op(dbg_mem_op), .dbg_rw(dbg_rw), .dbg_adr(dbg_adr), .dbg_do(dbg_do),
    .dbg_mem_rdy(dbg_mem_rdy), .dbg_di(dbg_di),
    .ibus_cmd_valid(ibus_cmd_valid), .ibus_cmd_ready(ibus_cmd_ready), .ibus_cmd_pc(ibus_cmd_pc),
    .ibus_rsp_valid(ibus_rsp_valid), .ibus_rsp_inst(ibus_rsp_inst), .ibus_rsp_error(ibus_rsp_error),
    .dbus_cmd_valid(dbus_cmd_valid), .dbus_cmd_ready(dbus_cmd_ready), .dbus_cmd_wr(dbus_cmd_wr),
    .dbus_cmd_mask(dbus_cmd_mask), .dbus_cmd_address(dbus_cmd_address),
    .dbus_cmd_data(dbus_cmd_data), .dbus_cmd_size(dbus_cmd_size),
    .dbus_rsp_ready(dbus_rsp_ready), .dbus_rsp_data(dbus_rsp_data), .dbus_rsp_error(dbus_rsp_error),
    .mem_op(mem_op), .mem_adr(mem_adr), .mem_di(mem_di), .mem_wren(mem_wren), .mem_do(mem_do)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  w;
    bit          care_b;
  } exp_t;

  exp_t q_mem[$];
  exp_t q_ibus[$];
  exp_t q_dbus[$];
  exp_t q_dbg[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  int acc_g, acc_d, acc_i, acc_x;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void fail_event(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: event seen with nothing expected (cycle %0d)", name, cyc);
  endfunction

  // Memory contents, hand-chosen per address.
  function automatic logic [31:0] model(input logic [31:0] adr);
    case (adr)
      32'h0002_0004: return 32'hDEAD_BEEF;
      32'h0000_0100: return 32'h0BAD_F00D;
      32'h0000_0200: return 32'h1111_2222;
      default:       return 32'hCAFE_0000;
    endcase
  endfunction

  // Memory model: data for a mem_op cycle appears in the following cycle,
  // otherwise mem_do carries junk so a mistimed capture is visible.
  logic        last_op;
  logic [31:0] last_adr;
  always @(negedge clk) begin
    last_op  = mem_op;
    last_adr = mem_adr;
  end
  initial begin
    mem_do = 32'd0;
    forever begin
      @(posedge clk);
      #1;
      mem_do = last_op ? model(last_adr) : $urandom;
    end
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (mon_en) begin
      if (mem_op) begin
        if (q_mem.size() == 0) fail_event("mem_op_unexpected");
        else begin
          e = q_mem.pop_front();
          chk("mem_cycle", 32'(cyc), 32'(e.cyc));
          chk("mem_adr", mem_adr, e.a);
          chk("mem_wren", {28'd0, mem_wren}, {28'd0, e.w});
          if (e.care_b) chk("mem_di", mem_di, e.b);
        end
      end else
        chk("mem_idle_zero", mem_adr | mem_di | {28'd0, mem_wren}, 32'd0);

      if (ibus_rsp_valid) begin
        if (q_ibus.size() == 0) fail_event("ibus_rsp_unexpected");
        else begin
          e = q_ibus.pop_front();
          chk("ibus_rsp_cycle", 32'(cyc), 32'(e.cyc));
          chk("ibus_rsp_inst", ibus_rsp_inst, e.a);
          chk("ibus_rsp_error", {31'd0, ibus_rsp_error}, {31'd0, e.w[0]});
        end
      end else
        chk("ibus_idle_zero", ibus_rsp_inst | {31'd0, ibus_rsp_error}, 32'd0);

      if (dbus_rsp_ready) begin
        if (q_dbus.size() == 0) fail_event("dbus_rsp_unexpected");
        else begin
          e = q_dbus.pop_front();
          chk("dbus_rsp_cycle", 32'(cyc), 32'(e.cyc));
          chk("dbus_rsp_data", dbus_rsp_data, e.a);
          chk("dbus_rsp_error", {31'd0, dbus_rsp_error}, {31'd0, e.w[0]});
        end
      end else
        chk("dbus_idle_zero", dbus_rsp_data | {31'd0, dbus_rsp_error}, 32'd0);

      if (dbg_mem_rdy) begin
        if (q_dbg.size() == 0) fail_event("dbg_rdy_unexpected");
        else begin
          e = q_dbg.pop_front();
          chk("dbg_rdy_cycle", 32'(cyc), 32'(e.cyc));
          chk("dbg_di", dbg_di, e.a);
        end
      end else
        chk("dbg_idle_zero", dbg_di, 32'd0);
    end
  end

  task automatic do_ibus(input logic [31:0] pc, input bit mapped, input logic [31:0] inst,
                         input bit drop_run, output int acc);
    exp_t e;
    bit got = 1'b0;
    ibus_cmd_pc    = pc;
    ibus_cmd_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ibus_cmd_ready) begin got = 1'b1; break; end
    end
    acc = cyc;
    if (!got) chk("ibus_accept_timeout", 32'd0, 32'd1);
    else if (mapped) begin
      e = '{cyc: acc + 1, a: {pc[31:2], 2'b00}, b: 32'd0, w: 4'h0, care_b: 1'b0};
      q_mem.push_back(e);
      e = '{cyc: acc + 3, a: inst, b: 32'd0, w: 4'h0, care_b: 1'b0};
      q_ibus.push_back(e);
    end else begin
      e = '{cyc: acc + 1, a: 32'd0, b: 32'd0, w: 4'h1, care_b: 1'b0};
      q_ibus.push_back(e);
    end
    @(posedge clk); #1;
    ibus_cmd_valid = 1'b0;
    if (drop_run) cpu_run = 1'b0;
  endtask

  task automatic do_dbus(input bit wr, input logic [3:0] mask, input logic [31:0] adr,
                         input logic [31:0] data, input bit mapped, input logic [31:0] rdata,
                         output int acc);
    exp_t e;
    bit got = 1'b0;
    dbus_cmd_wr      = wr;
    dbus_cmd_mask    = mask;
    dbus_cmd_address = adr;
    dbus_cmd_data    = data;
    dbus_cmd_size    = 2'd2;
    dbus_cmd_valid   = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (dbus_cmd_ready) begin got = 1'b1; break; end
    end
    acc = cyc;
    if (!got) chk("dbus_accept_timeout", 32'd0, 32'd1);
    else if (mapped && wr) begin
      e = '{cyc: acc + 1, a: {adr[31:2], 2'b00}, b: data, w: mask, care_b: 1'b1};
      q_mem.push_back(e);
    end else if (mapped) begin
      e = '{cyc: acc + 1, a: {adr[31:2], 2'b00}, b: 32'd0, w: 4'h0, care_b: 1'b0};
      q_mem.push_back(e);
      e = '{cyc: acc + 3, a: rdata, b: 32'd0, w: 4'h0, care_b: 1'b0};
      q_dbus.push_back(e);
    end else if (!wr) begin
      e = '{cyc: acc + 1, a: 32'd0, b: 32'd0, w: 4'h1, care_b: 1'b0};
      q_dbus.push_back(e);
    end
    @(posedge clk); #1;
    dbus_cmd_valid = 1'b0;
  endtask

  // Caller guarantees the arbiter is idle and re-armed, so the grant is immediate.
  task automatic do_dbg(input bit rw, input logic [31:0] adr, input logic [31:0] data,
                        input bit mapped, input logic [31:0] rdata, input int hold,
                        output int acc);
    exp_t e;
    bit got = 1'b0;
    dbg_rw     = rw;
    dbg_adr    = adr;
    dbg_do     = data;
    dbg_mem_op = 1'b1;
    @(negedge clk);
    acc = cyc;
    if (!mapped) begin
      e = '{cyc: acc + 1, a: 32'd0, b: 32'd0, w: 4'h0, care_b: 1'b0};
      q_dbg.push_back(e);
    end else if (rw) begin
      e = '{cyc: acc + 1, a: {adr[31:2], 2'b00}, b: 32'd0, w: 4'h0, care_b: 1'b0};
      q_mem.push_back(e);
      e = '{cyc: acc + 3, a: rdata, b: 32'd0, w: 4'h0, care_b: 1'b0};
      q_dbg.push_back(e);
    end else begin
      e = '{cyc: acc + 1, a: {adr[31:2], 2'b00}, b: data, w: 4'hF, care_b: 1'b1};
      q_mem.push_back(e);
      e = '{cyc: acc + 2, a: 32'd0, b: 32'd0, w: 4'h0, care_b: 1'b0};
      q_dbg.push_back(e);
    end
    if (dbg_mem_rdy) got = 1'b1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (dbg_mem_rdy) got = 1'b1;
    end
    if (!got) chk("dbg_rdy_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("dbg_held_no_regrant", {31'd0, mem_op | dbg_mem_rdy}, 32'd0);
      @(posedge clk); #1;
    end
    dbg_mem_op = 1'b0;
    @(negedge clk);
    chk("dbg_dropped_no_regrant", {31'd0, mem_op | dbg_mem_rdy}, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (q_mem.size() + q_ibus.size() + q_dbus.size() + q_dbg.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      chk("drain_timeout", 32'(q_mem.size() + q_ibus.size() + q_dbus.size() + q_dbg.size()), 32'd0);
      q_mem.delete(); q_ibus.delete(); q_dbus.delete(); q_dbg.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    exp_t e;
    bit got;
    reset = 1'b1; cpu_run = 1'b0;
    dbg_mem_op = 1'b0; dbg_rw = 1'b0; dbg_adr = 32'd0; dbg_do = 32'd0;
    ibus_cmd_valid = 1'b0; ibus_cmd_pc = 32'd0;
    dbus_cmd_valid = 1'b0; dbus_cmd_wr = 1'b0; dbus_cmd_mask = 4'h0;
    dbus_cmd_address = 32'd0; dbus_cmd_data = 32'd0; dbus_cmd_size = 2'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_strobes", {26'd0, mem_op, dbg_mem_rdy, ibus_rsp_valid, dbus_rsp_ready,
                          ibus_cmd_ready, dbus_cmd_ready}, 32'd0);
    chk("reset_data", mem_adr | mem_di | {28'd0, mem_wren} | dbg_di | ibus_rsp_inst | dbus_rsp_data, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; cpu_run = 1'b1; mon_en = 1'b1;

    // iBus read of a mapped word
    do_ibus(32'h0002_0004, 1'b1, 32'hDEAD_BEEF, 1'b0, acc_x);
    drain();

    // dBus byte-masked write, then an iBus request proves IDLE two cycles later
    do_dbus(1'b1, 4'b0011, 32'h0000_0010, 32'h1234_5678, 1'b1, 32'd0, acc_d);
    do_ibus(32'h0000_0100, 1'b1, 32'h0BAD_F00D, 1'b0, acc_i);
    chk("dbus_wr_idle_after_2", 32'(acc_i), 32'(acc_d + 2));
    drain();

    // dBus read with an unaligned address: memory sees the word address
    do_dbus(1'b0, 4'hF, 32'h0000_0202, 32'hFFFF_FFFF, 1'b1, 32'h1111_2222, acc_x);
    drain();

    // Unmapped: hole region, above ADR_BITS, dropped write, debug
    do_dbus(1'b0, 4'hF, 32'h0003_0000, 32'd0, 1'b0, 32'd0, acc_x);
    drain();
    do_ibus(32'h0004_0000, 1'b0, 32'd0, 1'b0, acc_x);
    drain();
    do_dbus(1'b1, 4'hF, 32'h0003_0010, 32'h7777_7777, 1'b0, 32'd0, acc_x);
    drain();
    do_dbg(1'b0, 32'h0008_0000, 32'h4444_4444, 1'b0, 32'd0, 0, acc_x);
    drain();

    // All three masters at once: debug, then dBus, then iBus
    fork
      do_dbg(1'b1, 32'h0000_0200, 32'd0, 1'b1, 32'h1111_2222, 0, acc_g);
      do_dbus(1'b1, 4'b1100, 32'h0000_0014, 32'hA5A5_5A5A, 1'b1, 32'd0, acc_d);
      do_ibus(32'h0000_0100, 1'b1, 32'h0BAD_F00D, 1'b0, acc_i);
    join
    chk("prio_dbus_after_dbg", 32'(acc_d), 32'(acc_g + 4));
    chk("prio_ibus_after_dbus", 32'(acc_i), 32'(acc_g + 6));
    drain();

    // Debug write held 3 cycles past rdy: no regrant; then a fresh read is granted at once
    do_dbg(1'b0, 32'h0000_0300, 32'h55AA_33CC, 1'b1, 32'd0, 3, acc_x);
    do_dbg(1'b1, 32'h0000_0200, 32'd0, 1'b1, 32'h1111_2222, 0, acc_x);
    drain();

    // cpu_run low blocks iBus
    cpu_run = 1'b0;
    ibus_cmd_pc = 32'h0000_0100;
    ibus_cmd_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("ibus_ready_cpu_stopped", {31'd0, ibus_cmd_ready}, 32'd0);
    end
    @(posedge clk); #1;
    cpu_run = 1'b1;
    do_ibus(32'h0000_0100, 1'b1, 32'h0BAD_F00D, 1'b0, acc_x);
    drain();

    // cpu_run falling mid-read does not abort it
    do_ibus(32'h0002_0004, 1'b1, 32'hDEAD_BEEF, 1'b1, acc_x);
    drain();
    cpu_run = 1'b1;

    // Reset during ACCESS of an iBus read drops it
    ibus_cmd_pc = 32'h0000_0100;
    ibus_cmd_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ibus_cmd_ready) begin got = 1'b1; break; end
    end
    acc_x = cyc;
    if (!got) chk("rst_ibus_accept_timeout", 32'd0, 32'd1);
    else begin
      e = '{cyc: acc_x + 1, a: 32'h0000_0100, b: 32'd0, w: 4'h0, care_b: 1'b0};
      q_mem.push_back(e);
    end
    @(posedge clk); #1;
    ibus_cmd_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    do_ibus(32'h0002_0004, 1'b1, 32'hDEAD_BEEF, 1'b0, acc_i);
    chk("idle_after_reset", 32'(acc_i), 32'(acc_x + 2));
    drain();

    chk("queues_empty", 32'(q_mem.size() + q_ibus.size() + q_dbus.size() + q_dbg.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_arb.md
MEM_BUS_ARB -- requirements
Module: mem_bus_arb

Interface
REQ-001 SHALL have parameter ADR_BITS, default 18; the width of the decoded address space. Addresses with any bit at or above ADR_BITS set are unmapped.
REQ-002 SHALL have parameter HOLE_REGION, default 2'b11; a value of adr[ADR_BITS-1:ADR_BITS-2] that is unmapped.
REQ-003 SHALL use one clock; reset is synchronous and active-high: clk input 1, the single clock; reset input 1, synchronous active-high reset.
REQ-004 cpu_run  input  1  when 0, no CPU (iBus/dBus) request is granted.
REQ-005 dbg_mem_op  input  1  debug request level, held until dbg_mem_rdy; dbg_rw  input  1  1=read, 0=write; dbg_adr  input  32; dbg_do  input  32  write data.
REQ-006 dbg_mem_rdy  output  1  one-cycle completion pulse; dbg_di  output  32  read data, valid with dbg_mem_rdy.
REQ-007 ibus_cmd_valid  input  1; ibus_cmd_ready  output  1; ibus_cmd_pc  input  32.
REQ-008 ibus_rsp_valid  output  1; ibus_rsp_inst  output  32; ibus_rsp_error  output  1.
REQ-009 dbus_cmd_valid  input  1; dbus_cmd_ready  output  1; dbus_cmd_wr  input  1; dbus_cmd_mask  input  4; dbus_cmd_address  input  32; dbus_cmd_data  input  32; dbus_cmd_size  input  2 (ignored; the mask is authoritative).
REQ-010 dbus_rsp_ready  output  1; dbus_rsp_data  output  32; dbus_rsp_error  output  1.
REQ-011 mem_op  output  1; mem_adr  output  32, word aligned, bits [1:0]=0; mem_di  output  32; mem_wren  output  4; mem_do  input  32, valid in the cycle after a mem_op cycle.

Function
REQ-012 FSM states SHALL be IDLE, ACCESS, WAIT, RESP, all registered. Granted command fields (master, address, data, wren, read flag) SHALL be latched at the grant edge.
REQ-013 Grant in IDLE SHALL use fixed priority: debug > dBus > iBus.
- dBus and iBus are eligible only when cpu_run=1.
- cmd_ready for the winner SHALL be combinational, asserted only in IDLE. A command is accepted on valid&ready.
REQ-014 Mapped grant SHALL go IDLE->ACCESS. In ACCESS: mem_op=1 with latched mem_adr/mem_di/mem_wren.
- Reads go ACCESS->WAIT. mem_do SHALL be captured at the end of WAIT, then WAIT->RESP.
- RESP SHALL pulse the matching response for exactly 1 cycle with the captured data, then go RESP->IDLE.
- Read latency: accept edge to response = 3 cycles.
REQ-015 mem_wren rules:
- dBus write: mem_wren = dbus_cmd_mask.
- Debug write: mem_wren = 4'hF.
- All reads: mem_wren = 4'h0.
REQ-016 Writes SHALL go ACCESS->IDLE.
- dBus writes produce no dbus_rsp_ready.
- Debug writes go ACCESS->RESP and pulse dbg_mem_rdy.
REQ-017 Unmapped address (REQ-001/002) SHALL not assert mem_op and SHALL go IDLE->RESP.
- Reads respond with error=1 and data 0.
- Debug requests get dbg_mem_rdy with dbg_di=0.
- Unmapped dBus writes are dropped silently.
REQ-018 A debug request SHALL be granted only if dbg_mem_op was 0 for at least one cycle since the last dbg_mem_rdy (re-arm flag).
REQ-019 Outside ACCESS: mem_op=0, mem_wren=0, mem_adr=0, mem_di=0. All rsp/rdy outputs SHALL be 0 outside RESP. Response data SHALL be 0 when its valid is low.
REQ-020 cpu_run falling mid-transaction SHALL NOT abort it; the transaction completes normally.
REQ-021 Simultaneous requests from all three masters SHALL be served one per transaction in priority order. The losers' valid is held, and they wait.

Reset
REQ-022 With reset=1 at an edge: state=IDLE, re-arm flag=1, all latched fields 0, all outputs 0.
REQ-023 Reset mid-transaction SHALL drop it with no response. If reset occurs in ACCESS, mem_op SHALL be 0 from the next cycle.

Verification
REQ-024 iBus read 0x0002_0004, mem_do=0xDEADBEEF in WAIT -> mem_op for 1 cycle with mem_adr=0x0002_0004; ibus_rsp_valid 3 cycles after accept, inst=0xDEADBEEF, error=0.
REQ-025 dBus write 0x0000_0010, mask=4'b0011, data=0x12345678 -> single ACCESS cycle with mem_wren=4'b0011; no dbus_rsp_ready; back in IDLE 2 cycles after accept.
REQ-026 dbg, dBus and iBus valid in the same cycle -> grants dbg, then dBus, then iBus; each mem_op cycle carries the correct address.
REQ-027 dBus read 0x0003_0000 -> no mem_op; dbus_rsp_ready with error=1 and data=0 one cycle after accept; iBus read 0x0004_0000 -> same behaviour on ibus_rsp_*.
REQ-028 dbg_mem_op held high for 3 cycles after dbg_mem_rdy -> no second grant until it has been low for 1 cycle. cpu_run=0 with ibus_cmd_valid=1 -> ibus_cmd_ready stays 0.
REQ-029 reset asserted in the ACCESS of a read -> next cycle mem_op=0, no ibus_rsp_valid, state IDLE.
